// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Fixed-latency issue/wait/done sequence with starvation-bounded priority.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [2:0]        d_funct3,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        mem_funct3,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic              own_q, own_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [2:0]        f3_q, f3_d;
   logic [3:0]        starve_q, starve_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] ifr_q, ifr_d;
   logic [DATA_W-1:0] dr_q, dr_d;
   logic              pick_d;
   logic              starved;
   logic              last_wait;

   assign starved   = (starve_q == 4'(STARVE_MAX));
   assign last_wait = (cnt_q <= 4'd1);

   // State and datapath registers; reset drops any transaction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         own_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         f3_q     <= '0;
         starve_q <= '0;
         cnt_q    <= '0;
         ifr_q    <= '0;
         dr_q     <= '0;
      end else begin
         state_q  <= state_d;
         own_q    <= own_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         f3_q     <= f3_d;
         starve_q <= starve_d;
         cnt_q    <= cnt_d;
         ifr_q    <= ifr_d;
         dr_q     <= dr_d;
      end
   end

   // Next-state sequencing: arbitrate only from IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (if_req || d_req) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (last_wait) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Winner latch, starvation count, wait countdown and result capture.
   always_comb begin
      pick_d   = 1'b0;
      own_d    = own_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      f3_d     = f3_q;
      starve_d = starve_q;
      cnt_d    = cnt_q;
      ifr_d    = ifr_q;
      dr_d     = dr_q;
      unique case (state_q)
         IDLE: begin
            pick_d = d_req && !(if_req && starved);
            if (if_req || d_req) begin
               own_d = pick_d;
               if (pick_d) begin
                  we_d    = d_we;
                  addr_d  = d_addr;
                  wdata_d = d_wdata;
                  f3_d    = d_funct3;
                  if (if_req && !starved)
                     starve_d = starve_q + 4'd1;
               end else begin
                  we_d     = 1'b0;
                  addr_d   = if_addr;
                  wdata_d  = '0;
                  f3_d     = 3'b010;
                  starve_d = '0;
               end
            end
         end
         ISSUE: cnt_d = 4'(MEM_LAT);
         WAIT: begin
            if (last_wait) begin
               cnt_d = '0;
               if (own_q)
                  dr_d = we_q ? '0 : mem_rdata;
               else
                  ifr_d = mem_rdata;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: ;
      endcase
   end

   // Memory strobes only in ISSUE; acks only in DONE for the owner.
   always_comb begin
      mem_en     = (state_q == ISSUE);
      mem_we     = (state_q == ISSUE) && we_q;
      mem_addr   = addr_q;
      mem_wdata  = wdata_q;
      mem_funct3 = f3_q;
      if_ack     = (state_q == DONE) && !own_q;
      d_ack      = (state_q == DONE) && own_q;
      if_rdata   = ifr_q;
      d_rdata    = dr_q;
      busy       = (state_q != IDLE);
      stall_if   = if_req && !((state_q == DONE) && !own_q);
      stall_mem  = d_req && !((state_q == DONE) && own_q);
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter at MEM_LAT 2, 1, 8.
// Each instance has its own fixed-latency memory model and shadow copy.
module tb_mem_port_arbiter;

   logic clk;
   int   total = 0;
   int   bad   = 0;
   bit   fin [3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] memf(input int i);
      logic [7:0] b;
      b = i[7:0];
      if (i == 64) return 32'h00500093;
      return {b ^ 8'h5A, 8'h11, b, 8'hC3};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : u
      localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 8;

      logic        rst, if_req, if_ack, d_req, d_we, d_ack;
      logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
      logic [2:0]  d_funct3, mem_funct3;
      logic        mem_en, mem_we, stall_if, stall_mem, busy;
      logic [31:0] mem_addr, mem_wdata, mem_rdata;
      logic [31:0] mem [0:255];
      logic [7:0]  pa [0:L-1];
      logic [31:0] sh [0:255];
      bit          minit = 1'b0;

      mem_port_arbiter #(.MEM_LAT(L), .STARVE_MAX(4)) dut (
         .clk(clk), .rst(rst),
         .if_req(if_req), .if_addr(if_addr),
         .if_ack(if_ack), .if_rdata(if_rdata),
         .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
         .d_wdata(d_wdata), .d_funct3(d_funct3),
         .d_ack(d_ack), .d_rdata(d_rdata),
         .mem_en(mem_en), .mem_we(mem_we),
         .mem_addr(mem_addr), .mem_wdata(mem_wdata),
         .mem_funct3(mem_funct3), .mem_rdata(mem_rdata),
         .stall_if(stall_if), .stall_mem(stall_mem),
         .busy(busy)
      );

      always @(posedge clk) begin
         if (!minit) begin
            for (int i = 0; i < 256; i++) mem[i] <= memf(i);
            minit <= 1'b1;
         end else if (mem_en && mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
         end
         pa[0] <= mem_addr[9:2];
         for (int i = 1; i < L; i++) pa[i] <= pa[i-1];
      end
      assign mem_rdata = mem[pa[L-1]];

      task automatic txn(input bit isd, input bit we,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, input logic [31:0] ex,
                         input string tag);
         int n, en_n;
         logic en_we, other;
         logic [31:0] en_a, en_wd, rd;
         logic [2:0] en_f3;
         bit ack;
         @(negedge clk);
         if (isd) begin
            d_req = 1; d_we = we; d_addr = a;
            d_wdata = wd; d_funct3 = f3;
         end else begin
            if_req = 1; if_addr = a;
         end
         n = 0; en_n = 0; ack = 0;
         en_we = 0; en_a = 0; en_wd = 0; en_f3 = 0;
         other = 0; rd = 0;
         while (!ack && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
               if_addr = a ^ 32'h3FC;
               d_addr  = a ^ 32'h3FC;
               d_wdata = ~wd;
            end
            if (mem_en) begin
               en_n = n; en_we = mem_we; en_a = mem_addr;
               en_wd = mem_wdata; en_f3 = mem_funct3;
            end
            ack = isd ? d_ack : if_ack;
            if (ack) begin
               other = isd ? if_ack : d_ack;
               rd = isd ? d_rdata : if_rdata;
            end
         end
         chk({tag, "_lat"}, n, L + 2);
         chk({tag, "_en_cyc"}, en_n, 1);
         chk({tag, "_maddr"}, en_a, a);
         chk({tag, "_mwe"}, en_we, isd && we);
         chk({tag, "_mf3"}, en_f3, isd ? f3 : 3'b010);
         if (isd && we) chk({tag, "_mwdata"}, en_wd, wd);
         chk({tag, "_rdata"}, rd, ex);
         chk({tag, "_other_ack"}, other, 0);
         if_req = 0;
         d_req  = 0;
      endtask

      initial begin
         rst = 0; if_req = 0; d_req = 0; d_we = 0;
         if_addr = 0; d_addr = 0; d_wdata = 0; d_funct3 = 0;
         for (int i = 0; i < 256; i++) sh[i] = memf(i);
      end

      if (g == 0) begin : dir
         initial begin
            int k, both;
            bit sawack;
            logic [9:0] order;
            #1;
            repeat (3) @(negedge clk);
            if_req = 1;
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_acks", {if_ack, d_ack}, 0);
            chk("rst_maddr", mem_addr, 0);
            chk("rst_mwdata", mem_wdata, 0);
            chk("rst_mf3", mem_funct3, 0);
            chk("rst_rdata", {if_rdata, d_rdata}, 0);
            chk("rst_stall_if", stall_if, 1);
            chk("rst_stall_mem", stall_mem, 0);
            if_req = 0;
            @(negedge clk);
            rst = 1;

            txn(0, 0, 32'h100, 0, 3'b010, 32'h00500093, "fetch");
            txn(1, 1, 32'h40, 32'hDEADBEEF, 3'b010, 0, "store");
            txn(1, 0, 32'h40, 0, 3'b010, 32'hDEADBEEF, "load");
            txn(1, 0, 32'h14, 0, 3'b100, memf(5), "load_b");

            @(negedge clk);
            if_addr = 32'h100; d_addr = 32'h80;
            d_we = 0; d_funct3 = 3'b010;
            if_req = 1; d_req = 1;
            k = 0; both = 0; order = 0;
            for (int c = 0; c < 200 && k < 10; c++) begin
               @(negedge clk);
               if (if_ack && d_ack) both++;
               if (if_ack || d_ack) begin
                  order = {order[8:0], d_ack};
                  k++;
                  if (k == 1) begin
                     chk("arb_stall_mem", stall_mem, 0);
                     chk("arb_stall_if", stall_if, 1);
                  end
                  if (k == 5)
                     chk("arb_f_rdata", if_rdata, 32'h00500093);
               end
            end
            if_req = 0; d_req = 0;
            chk("arb_cnt", k, 10);
            chk("arb_order", order, 10'b1111011110);
            chk("arb_dual_ack", both, 0);

            @(negedge clk);
            d_req = 1; d_we = 0; d_addr = 32'h40;
            repeat (2) @(negedge clk);
            chk("mid_busy", busy, 1);
            rst = 0;
            #1;
            chk("mid_mem_en", mem_en, 0);
            chk("mid_busy0", busy, 0);
            chk("mid_stall_mem", stall_mem, 1);
            sawack = 0;
            repeat (4) begin
               @(negedge clk);
               if (d_ack) sawack = 1;
            end
            chk("mid_no_ack", sawack, 0);
            d_req = 0;
            @(negedge clk);
            rst = 1;
            txn(1, 0, 32'h40, 0, 3'b010, 32'hDEADBEEF, "reissue");
            fin[g] = 1;
         end
      end else begin : rnd
         initial begin
            int kind, idx;
            logic [31:0] wd;
            #1;
            repeat (3) @(negedge clk);
            rst = 1;
            for (int t = 0; t < 25; t++) begin
               kind = $urandom_range(0, 2);
               idx  = $urandom_range(0, 15);
               wd   = $urandom;
               if (kind == 0)
                  txn(0, 0, idx << 2, 0, 3'b010, sh[idx], "r_fetch");
               else if (kind == 1)
                  txn(1, 0, idx << 2, 0, 3'b000, sh[idx], "r_load");
               else begin
                  txn(1, 1, idx << 2, wd, 3'b001, 0, "r_store");
                  sh[idx] = wd;
               end
            end
            fin[g] = 1;
         end
      end
   end

   initial begin
      for (int c = 0; c < 20000; c++) begin
         if (fin[0] && fin[1] && fin[2]) break;
         @(negedge clk);
      end
      chk("all_done", {fin[0], fin[1], fin[2]}, 3'b111);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line, name, default, meaning:
  ADDR_W  32  address width.
  DATA_W  32  data width.
  MEM_LAT  2  memory read/write latency in cycles, legal range 1..8.
  STARVE_MAX  4  consecutive data grants allowed while a fetch waits, legal range 1..15.
REQ-002 Ports SHALL be, one per line, name, direction, width, meaning:
  clk  in  1  single clock; all state changes on the rising edge.
  rst  in  1  asynchronous, active-low reset.
  if_req  in  1  fetch request, held high until if_ack.
  if_addr  in  ADDR_W  fetch address.
  if_ack  out  1  one-cycle fetch completion.
  if_rdata  out  DATA_W  fetched instruction, valid while if_ack=1.
  d_req  in  1  data request, held high until d_ack.
  d_we  in  1  1=store, 0=load.
  d_addr  in  ADDR_W  data address.
  d_wdata  in  DATA_W  store data.
  d_funct3  in  3  access size/sign code, passed through.
  d_ack  out  1  one-cycle data completion.
  d_rdata  out  DATA_W  load data, valid while d_ack=1.
  mem_en  out  1  memory access strobe.
  mem_we  out  1  memory write enable.
  mem_addr  out  ADDR_W  memory address.
  mem_wdata  out  DATA_W  memory write data.
  mem_funct3  out  3  memory size code; 3'b010 (word) for fetches.
  mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle.
  stall_if  out  1  if_req & ~if_ack.
  stall_mem  out  1  d_req & ~d_ack.
  busy  out  1  high in every state except IDLE.

Function
REQ-003 The block SHALL share one memory port between fetch and data requesters via FSM states IDLE, ISSUE, WAIT, DONE.
REQ-004 IDLE: at a rising edge with if_req or d_req high, the block SHALL latch the winner's address, we, wdata and funct3, and go to ISSUE; otherwise it stays in IDLE.
REQ-005 Arbitration SHALL happen only in IDLE; a request raised in any other state waits.
REQ-006 If only one requester is pending, it SHALL win.
REQ-007 If both are pending, data SHALL win unless starve_cnt == STARVE_MAX, in which case fetch SHALL win.
REQ-008 starve_cnt SHALL increment on a data grant made while if_req=1, hold on a data grant made while if_req=0, and clear to 0 on any fetch grant.
REQ-009 starve_cnt SHALL saturate at STARVE_MAX.
REQ-010 ISSUE lasts exactly 1 cycle: mem_en=1 and the latched fields drive mem_we, mem_addr, mem_wdata and mem_funct3.
REQ-011 mem_we SHALL be 0 for fetch grants.
REQ-012 In every non-ISSUE cycle, mem_en=0 and mem_we=0.
REQ-013 WAIT SHALL last MEM_LAT cycles, counted by a down-counter.
REQ-014 At the edge ending the final WAIT cycle, the block SHALL capture mem_rdata into a result register and go to DONE.
REQ-015 DONE lasts 1 cycle: the owner's ack=1; if_rdata/d_rdata show the captured data (loads and fetches); the state then returns to IDLE.
REQ-016 d_rdata SHALL be 0 on a store ack.
REQ-017 Both acks SHALL never be high in the same cycle.
REQ-018 Latency SHALL be fixed: request sampled at edge E, ack high in the cycle after edge E+MEM_LAT+1. For MEM_LAT=2, the ack appears in the 4th cycle after the sampling edge.
REQ-019 A requester SHALL drop req at the edge ending its ack cycle; req still high at the end of the following IDLE cycle is a new request.
REQ-020 The block SHALL ignore changes to a requester's inputs after latching; only latched values drive the memory.
REQ-021 Data and rdata output registers not named in REQ-015 SHALL hold their last value; they are qualified only by ack.

Reset
REQ-022 When rst=0, the block SHALL asynchronously force state=IDLE, starve_cnt=0, the WAIT counter=0, and outputs mem_en=0, mem_we=0, if_ack=0, d_ack=0, busy=0, if_rdata=0, d_rdata=0, mem_addr=0, mem_wdata=0, mem_funct3=0.
REQ-023 Reset in mid-transaction SHALL drop the transaction with no ack; requesters reissue after reset.
REQ-024 stall_if/stall_mem SHALL follow req while in reset.

Verification
REQ-025 Lone fetch, MEM_LAT=2, if_addr=0x100, memory word 0x00500093: mem_en one cycle after the sampling edge, if_ack in the 4th cycle, if_rdata=0x00500093.
REQ-026 Store then load, d_addr=0x40: store d_wdata=0xDEADBEEF with mem_we=1 and d_ack, d_rdata=0; the following load returns 0xDEADBEEF.
REQ-027 Simultaneous if_req and d_req held continuously, STARVE_MAX=4: grant order D,D,D,D,F,D,D,D,D,F; no two acks in the same cycle.
REQ-028 rst pulsed low during WAIT of a load: mem_en=0 and busy=0 immediately, no d_ack; after rst release and reissue, normal 4-cycle completion.
REQ-029 MEM_LAT=1 and MEM_LAT=8 sweep with random back-to-back requests: ack exactly MEM_LAT+2 cycles after each sampling edge, and a scoreboard matches all data.
